// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA-256 block constants and UART receive state types
package sha_pkg;

    localparam int SHA_BLOCK_W = 512;
    localparam int SHA_LEN_W = 64;
    localparam logic [7:0] SHA_PAD_BYTE = 8'h80;
    localparam int MAX_PAYLOAD = 55;
    localparam int LEN_W = 6;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        ASM_COLLECT,
        ASM_PAD,
        ASM_VALID
    } asm_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - synchronised 8N1 UART byte receiver (8E1 with UART_RX_PARITY_EN)
module uart_rx_byte
    import sha_pkg::*;
#(
    parameter int CLK_FREQ = 60000000,
    parameter int BAUD = 115200
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       RXD,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

    rx_state_e        state;
    logic             rxd_m;
    logic             rxd_s;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
`ifdef UART_RX_PARITY_EN
    logic             par_err;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rxd_m     <= 1'b1;
            rxd_s     <= 1'b1;
            state     <= RX_IDLE;
            armed     <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            rxd_m     <= RXD;
            rxd_s     <= rxd_m;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    // Only a high-to-low transition starts a frame; a stuck-low line never re-arms
                    if (rxd_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed <= 1'b0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_err <= (rxd_s != ^shreg);
                        state   <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (rxd_s && !par_err) begin
`else
                        if (rxd_s) begin
`endif
                            rx_byte  <= shreg;
                            byte_vld <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_msg_rx.sv
// rtl/uart_msg_rx.sv - UART message collector emitting one padded SHA-256 block
// Optional even-parity frames when UART_RX_PARITY_EN is defined.
module uart_msg_rx
    import sha_pkg::*;
#(
    parameter int CLK_FREQ = 60000000,
    parameter int BAUD = 115200,
    parameter int MAX_LEN = MAX_PAYLOAD,
    parameter logic [7:0] TERM = 8'h0a
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   RXD,
    output logic [0:SHA_BLOCK_W-1] msg,
    output logic                   msg_valid,
    input  logic                   msg_ack,
    output logic                   frame_err,
    output logic                   overflow
);

    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

    logic [7:0]             rx_byte;
    logic                   byte_vld;
    asm_state_e             state;
    logic [LEN_W-1:0]       len;
    logic [7:0]             buf_mem [0:MAX_LEN-1];
    logic [SHA_BLOCK_W-1:0] padded;

    uart_rx_byte #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) u_rx (
        .CLK      (CLK),
        .reset    (reset),
        .RXD      (RXD),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frame_err(frame_err)
    );

    always_ff @(posedge CLK) begin
        if (state == ASM_COLLECT && byte_vld && rx_byte != TERM) begin
            buf_mem[len] <= rx_byte;
        end
    end

    // Byte i occupies the i-th octet from the MSB end; stale buffer entries past len are masked
    always_comb begin
        padded = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len) begin
                padded[SHA_BLOCK_W-1-8*i -: 8] = buf_mem[i];
            end
        end
        for (int i = 0; i <= MAX_LEN; i++) begin
            if (LEN_W'(i) == len) begin
                padded[SHA_BLOCK_W-1-8*i -: 8] = SHA_PAD_BYTE;
            end
        end
        padded[SHA_LEN_W-1:0] = {{(SHA_LEN_W-LEN_W-3){1'b0}}, len, 3'b000};
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= ASM_COLLECT;
            len       <= '0;
            msg       <= '0;
            msg_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            case (state)
                ASM_COLLECT: begin
                    if (byte_vld) begin
                        if (rx_byte == TERM) begin
                            state <= ASM_PAD;
                        end else begin
                            len <= len + 1'b1;
                            if (len == LEN_LAST) begin
                                state <= ASM_PAD;
                            end
                        end
                    end
                end
                ASM_PAD: begin
                    msg       <= padded;
                    msg_valid <= 1'b1;
                    state     <= ASM_VALID;
                    overflow  <= byte_vld;
                end
                ASM_VALID: begin
                    overflow <= byte_vld;
                    if (msg_ack) begin
                        msg_valid <= 1'b0;
                        len       <= '0;
                        state     <= ASM_COLLECT;
                    end
                end
                default: state <= ASM_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_rx.sv
// tb/tb_uart_msg_rx.sv - directed table-driven bench for uart_msg_rx at DIV=16
module tb_uart_msg_rx;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic         RXD = 1'b1;
    logic         msg_ack = 1'b0;
    logic [511:0] msg;
    logic         msg_valid;
    logic         frame_err;
    logic         overflow;

    always #5 CLK = ~CLK;

    uart_msg_rx #(
        .CLK_FREQ(1600),
        .BAUD    (100)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .RXD      (RXD),
        .msg      (msg),
        .msg_valid(msg_valid),
        .msg_ack  (msg_ack),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    typedef struct {
        string        nm;
        int           n;
        logic [447:0] pay;
        logic [511:0] exp;
    } vec_t;

    vec_t vecs [5];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   fe_rise = 0, fe_hi = 0, ov_rise = 0, ov_hi = 0;
    logic fe_prev = 1'b0, ov_prev = 1'b0;

    always @(negedge CLK) begin
        if (frame_err) fe_hi++;
        if (frame_err && !fe_prev) fe_rise++;
        fe_prev = frame_err;
        if (overflow) ov_hi++;
        if (overflow && !ov_prev) ov_rise++;
        ov_prev = overflow;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RXD = b;
        repeat (16) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
    endtask

    task automatic wait_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (msg_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic do_ack;
        msg_ack = 1'b1;
        @(negedge CLK);
        msg_ack = 1'b0;
    endtask

    initial begin
        logic ok;
        int   fe0, fh0, ov0, oh0;

        vecs[0] = '{"abc", 4, {"abc\n", 416'h0}, {32'h61626380, 416'h0, 64'h18}};
        vecs[1] = '{"empty", 1, {8'h0a, 440'h0}, {8'h80, 440'h0, 64'h0}};
        vecs[2] = '{"full55", 55, {56{8'h41}}, {{55{8'h41}}, 8'h80, 64'h1b8}};
        vecs[3] = '{"hello", 6, {"hello\n", 400'h0}, {40'h68656c6c6f, 8'h80, 400'h0, 64'h28}};
        vecs[4] = '{"len54", 55, {{54{8'h42}}, 8'h0a, 8'h00}, {{54{8'h42}}, 8'h80, 8'h00, 64'h1b0}};

        repeat (3) @(negedge CLK);
        chk("rst_msg", msg, 512'h0);
        chk("rst_valid", {511'h0, msg_valid}, 512'h0);
        chk("rst_ferr", {511'h0, frame_err}, 512'h0);
        chk("rst_ovf", {511'h0, overflow}, 512'h0);
        reset = 1'b1;
        repeat (5) @(negedge CLK);

        for (int k = 0; k < 5; k++) begin
            fe0 = fe_rise;
            ov0 = ov_rise;
            for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].pay[447-8*i -: 8], 1'b1);
            wait_valid(ok);
            chk({vecs[k].nm, "_valid"}, {511'h0, ok}, 512'h1);
            chk({vecs[k].nm, "_msg"}, msg, vecs[k].exp);
            chk({vecs[k].nm, "_noerr"}, 512'(fe_rise - fe0 + ov_rise - ov0), 512'h0);
            do_ack();
            chk({vecs[k].nm, "_ackdrop"}, {511'h0, msg_valid}, 512'h0);
            repeat (4) @(negedge CLK);
        end

        // Bad stop bit on 'a': one frame_err pulse, byte discarded
        fe0 = fe_rise;
        fh0 = fe_hi;
        send_byte(8'h61, 1'b0);
        RXD = 1'b1;
        repeat (20) @(negedge CLK);
        chk("ferr_pulses", 512'(fe_rise - fe0), 512'h1);
        chk("ferr_width", 512'(fe_hi - fh0), 512'h1);
        chk("ferr_novalid", {511'h0, msg_valid}, 512'h0);
        send_byte(8'h62, 1'b1);
        send_byte(8'h0a, 1'b1);
        wait_valid(ok);
        chk("ferr_next_msg", msg, {16'h6280, 432'h0, 64'h8});
        do_ack();

        // Two-cycle glitch on idle line: nothing received, no error
        repeat (10) @(negedge CLK);
        fe0 = fe_rise;
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        RXD = 1'b1;
        repeat (40) @(negedge CLK);
        chk("glitch_noerr", 512'(fe_rise - fe0), 512'h0);
        chk("glitch_novalid", {511'h0, msg_valid}, 512'h0);
        send_byte(8'h0a, 1'b1);
        wait_valid(ok);
        chk("glitch_empty_msg", msg, {8'h80, 440'h0, 64'h0});
        do_ack();

        // Reset mid-DATA, then a clean frame
        repeat (10) @(negedge CLK);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        chk("midrst_msg", msg, 512'h0);
        chk("midrst_valid", {511'h0, msg_valid}, 512'h0);
        chk("midrst_flags", {510'h0, frame_err, overflow}, 512'h0);
        RXD = 1'b1;
        reset = 1'b1;
        repeat (20) @(negedge CLK);
        send_byte(8'h7a, 1'b1);
        send_byte(8'h0a, 1'b1);
        wait_valid(ok);
        chk("midrst_next_msg", msg, {16'h7a80, 432'h0, 64'h8});
        do_ack();

        // Byte while block held: overflow pulse, msg untouched, then ack
        repeat (10) @(negedge CLK);
        send_byte(8'h71, 1'b1);
        send_byte(8'h0a, 1'b1);
        wait_valid(ok);
        chk("ovf_msg_before", msg, {16'h7180, 432'h0, 64'h8});
        ov0 = ov_rise;
        oh0 = ov_hi;
        send_byte(8'h78, 1'b1);
        repeat (20) @(negedge CLK);
        chk("ovf_pulses", 512'(ov_rise - ov0), 512'h1);
        chk("ovf_width", 512'(ov_hi - oh0), 512'h1);
        chk("ovf_msg_held", msg, {16'h7180, 432'h0, 64'h8});
        chk("ovf_valid_held", {511'h0, msg_valid}, 512'h1);
        do_ack();
        chk("ovf_ackdrop", {511'h0, msg_valid}, 512'h0);
        send_byte(8'h0a, 1'b1);
        wait_valid(ok);
        chk("ovf_after_empty", msg, {8'h80, 440'h0, 64'h0});
        do_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
